alarm_controller: RTL and testbench



---
 rtl/alarm_pkg.sv | 18 +
 rtl/time_add_minutes.sv | 33 +++
 rtl/alarm_controller.sv | 147 ++++++++++++++
 tb/tb_alarm_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller and its time helper.
package alarm_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;
  localparam int HOUR_W        = 5;
  localparam int MIN_W         = 6;
  localparam int SEC_W         = 6;
  localparam int SNZ_CNT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

endpackage

// File: rtl/time_add_minutes.sv
// Combinational HH:MM + ADD_MIN with minute carry into hours and wrap at midnight.
module time_add_minutes
  import alarm_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [HOUR_W-1:0] i_hour,
  input  logic [MIN_W-1:0]  i_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic [MIN_W-1:0]  o_min
);

  localparam logic [MIN_W:0]  ADD_W     = (MIN_W+1)'(ADD_MIN);
  localparam logic [MIN_W:0]  MIN_LIMIT = (MIN_W+1)'(MIN_PER_HOUR);
  localparam logic [HOUR_W:0] HR_LIMIT  = (HOUR_W+1)'(HOURS_PER_DAY);

  logic [MIN_W:0]  w_minSum;
  logic [MIN_W:0]  w_minWrapped;
  logic            w_carry;
  logic [HOUR_W:0] w_hourSum;
  logic [HOUR_W:0] w_hourWrapped;

  always_comb begin
    w_minSum      = {1'b0, i_min} + ADD_W;
    w_carry       = (w_minSum >= MIN_LIMIT);
    w_minWrapped  = w_carry ? (w_minSum - MIN_LIMIT) : w_minSum;
    w_hourSum     = {1'b0, i_hour} + {{HOUR_W{1'b0}}, w_carry};
    w_hourWrapped = (w_hourSum >= HR_LIMIT) ? (w_hourSum - HR_LIMIT) : w_hourSum;
    o_min         = w_minWrapped[MIN_W-1:0];
    o_hour        = w_hourWrapped[HOUR_W-1:0];
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm FSM watching the live time-of-day: programmable HH:MM, snooze with retry limit,
// ring timeout and a valid/ready port for loading the alarm time.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SEC_W-1:0]     seconds,
  input  logic [MIN_W-1:0]     minutes,
  input  logic [HOUR_W-1:0]    hours,
  input  logic                 set_valid,
  output logic                 set_ready,
  input  logic [HOUR_W-1:0]    set_hour,
  input  logic [MIN_W-1:0]     set_min,
  output logic                 set_err,
  input  logic                 arm,
  input  logic                 snooze,
  input  logic                 dismiss,
  output logic [HOUR_W-1:0]    alarm_hour,
  output logic [MIN_W-1:0]     alarm_min,
  output logic                 armed,
  output logic                 ringing,
  output logic                 snooze_active,
  output logic [SNZ_CNT_W-1:0] snooze_count
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  state_t                r_state;
  logic [7:0]            r_ringCnt;
  logic [HOUR_W-1:0]     r_alarmHour;
  logic [MIN_W-1:0]      r_alarmMin;
  logic [HOUR_W-1:0]     r_snzHour;
  logic [MIN_W-1:0]      r_snzMin;
  logic                  r_ringing;
  logic                  r_setErr;
  logic [SNZ_CNT_W-1:0]  r_snoozeCount;

  logic                  w_match;
  logic                  w_snzMatch;
  logic                  w_xfer;
  logic                  w_setBad;
  logic                  w_snoozeOk;
  logic                  w_timeout;
  logic [HOUR_W-1:0]     w_tgtHour;
  logic [MIN_W-1:0]      w_tgtMin;

  time_add_minutes #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_snoozeTarget (
    .i_hour (hours),
    .i_min  (minutes),
    .o_hour (w_tgtHour),
    .o_min  (w_tgtMin)
  );

  // seconds==0 holds for a single cycle per minute, so a level compare fires exactly once
  assign w_match    = (hours == r_alarmHour) && (minutes == r_alarmMin) && (seconds == '0);
  assign w_snzMatch = (hours == r_snzHour) && (minutes == r_snzMin) && (seconds == '0);
  assign set_ready  = (r_state == ST_IDLE) || (r_state == ST_ARMED);
  assign w_xfer     = set_valid && set_ready;
  assign w_setBad   = (set_hour > HOUR_W'(HOURS_PER_DAY - 1)) ||
                      (set_min > MIN_W'(MIN_PER_HOUR - 1));
  assign w_snoozeOk = (int'(r_snoozeCount) < MAX_SNOOZE);
  assign w_timeout  = (r_ringCnt == RING_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_ringCnt     <= '0;
      r_alarmHour   <= '0;
      r_alarmMin    <= '0;
      r_snzHour     <= '0;
      r_snzMin      <= '0;
      r_ringing     <= 1'b0;
      r_setErr      <= 1'b0;
      r_snoozeCount <= '0;
    end else begin
      r_setErr <= w_xfer && w_setBad;
      if (w_xfer && !w_setBad) begin
        r_alarmHour <= set_hour;
        r_alarmMin  <= set_min;
      end

      if (!arm) begin
        r_state       <= ST_IDLE;
        r_ringing     <= 1'b0;
        r_snoozeCount <= '0;
        r_ringCnt     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_ARMED;
          ST_ARMED: begin
            if (w_match) begin
              r_state   <= ST_RINGING;
              r_ringing <= 1'b1;
              r_ringCnt <= '0;
            end
          end
          ST_RINGING: begin
            if (dismiss) begin
              r_state       <= ST_ARMED;
              r_ringing     <= 1'b0;
              r_snoozeCount <= '0;
            end else if (snooze && w_snoozeOk) begin
              r_state       <= ST_SNOOZE;
              r_ringing     <= 1'b0;
              r_snoozeCount <= r_snoozeCount + 1'b1;
              r_snzHour     <= w_tgtHour;
              r_snzMin      <= w_tgtMin;
            end else if (w_timeout) begin
              r_state       <= ST_ARMED;
              r_ringing     <= 1'b0;
              r_snoozeCount <= '0;
            end else begin
              r_ringCnt <= r_ringCnt + 1'b1;
            end
          end
          ST_SNOOZE: begin
            if (dismiss) begin
              r_state       <= ST_ARMED;
              r_snoozeCount <= '0;
            end else if (w_snzMatch) begin
              r_state   <= ST_RINGING;
              r_ringing <= 1'b1;
              r_ringCnt <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign alarm_hour    = r_alarmHour;
  assign alarm_min     = r_alarmMin;
  assign ringing       = r_ringing;
  assign set_err       = r_setErr;
  assign snooze_count  = r_snoozeCount;
  assign armed         = (r_state != ST_IDLE);
  assign snooze_active = (r_state == ST_SNOOZE);

endmodule

// File: tb/tb_alarm_controller.sv
// Directed plus randomized bench for alarm_controller against a seconds-of-day reference model.
module tb_alarm_controller;

  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic       set_err;
  logic       arm = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       armed;
  logic       ringing;
  logic       snooze_active;
  logic [2:0] snooze_count;

  int compared = 0;
  int mismatched = 0;

  int tod = 0;
  bit mArmed, mRinging, mSnoozing, mErr;
  int mRingLeft, mSnoozes, mSnoozeAt, mAlarmH, mAlarmM;

  alarm_controller #(
    .RING_SECS  (RING_SECS),
    .SNOOZE_MIN (SNOOZE_MIN),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .seconds       (seconds),
    .minutes       (minutes),
    .hours         (hours),
    .set_valid     (set_valid),
    .set_ready     (set_ready),
    .set_hour      (set_hour),
    .set_min       (set_min),
    .set_err       (set_err),
    .arm           (arm),
    .snooze        (snooze),
    .dismiss       (dismiss),
    .alarm_hour    (alarm_hour),
    .alarm_min     (alarm_min),
    .armed         (armed),
    .ringing       (ringing),
    .snooze_active (snooze_active),
    .snooze_count  (snooze_count)
  );

  always #5 clk = ~clk;

  task automatic driveTime();
    hours   = 5'(tod / 3600);
    minutes = 6'((tod / 60) % 60);
    seconds = 6'(tod % 60);
  endtask

  task automatic setTime(input int h, input int m, input int s);
    tod = h * 3600 + m * 60 + s;
    driveTime();
  endtask

  // Reference behaviour: times as minute-of-day integers, ring length as a countdown
  task automatic modelStep();
    bit hit, xfer, bad;
    int nowMin;
    if (!reset_n) begin
      mArmed = 0; mRinging = 0; mSnoozing = 0; mErr = 0;
      mRingLeft = 0; mSnoozes = 0; mSnoozeAt = 0; mAlarmH = 0; mAlarmM = 0;
      return;
    end
    nowMin = tod / 60;
    hit    = (tod % 60 == 0) && (nowMin == mAlarmH * 60 + mAlarmM);
    xfer   = set_valid && !mRinging && !mSnoozing;
    bad    = (set_hour > 23) || (set_min > 59);
    mErr   = xfer && bad;
    if (!arm) begin
      mArmed = 0; mRinging = 0; mSnoozing = 0; mSnoozes = 0;
    end else if (!mArmed) begin
      mArmed = 1;
    end else if (mRinging) begin
      if (dismiss) begin
        mRinging = 0; mSnoozes = 0;
      end else if (snooze && mSnoozes < MAX_SNOOZE) begin
        mRinging = 0; mSnoozing = 1; mSnoozes++;
        mSnoozeAt = (nowMin + SNOOZE_MIN) % 1440;
      end else if (mRingLeft == 1) begin
        mRinging = 0; mSnoozes = 0;
      end else begin
        mRingLeft--;
      end
    end else if (mSnoozing) begin
      if (dismiss) begin
        mSnoozing = 0; mSnoozes = 0;
      end else if (tod % 60 == 0 && nowMin == mSnoozeAt) begin
        mSnoozing = 0; mRinging = 1; mRingLeft = RING_SECS;
      end
    end else if (hit) begin
      mRinging = 1; mRingLeft = RING_SECS;
    end
    if (xfer && !bad) begin
      mAlarmH = int'(set_hour);
      mAlarmM = int'(set_min);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("ringing", {7'b0, ringing}, {7'b0, mRinging});
    checkOutput("armed", {7'b0, armed}, {7'b0, mArmed});
    checkOutput("snooze_active", {7'b0, snooze_active}, {7'b0, mSnoozing});
    checkOutput("snooze_count", {5'b0, snooze_count}, 8'(mSnoozes));
    checkOutput("set_ready", {7'b0, set_ready}, {7'b0, !mRinging && !mSnoozing});
    checkOutput("set_err", {7'b0, set_err}, {7'b0, mErr});
    checkOutput("alarm_hour", {3'b0, alarm_hour}, 8'(mAlarmH));
    checkOutput("alarm_min", {2'b0, alarm_min}, 8'(mAlarmM));
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      modelStep();
      @(posedge clk);
      #1;
      checkAll();
      tod = (tod + 1) % 86400;
      driveTime();
    end
  endtask

  task automatic offerTime(input int h, input int m);
    set_valid = 1'b1; set_hour = 5'(h); set_min = 6'(m);
    applyStimulus(1);
    set_valid = 1'b0;
  endtask

  task automatic pulseSnooze();
    snooze = 1'b1; applyStimulus(1); snooze = 1'b0;
  endtask

  initial begin
    int k;
    driveTime();
    applyStimulus(2);
    reset_n = 1'b1;
    applyStimulus(1);
    checkOutput("ready_after_reset", {7'b0, set_ready}, 8'd1);

    offerTime(7, 30);
    arm = 1'b1;
    applyStimulus(1);
    setTime(7, 29, 55);
    applyStimulus(6);
    checkOutput("ring_at_0730", {7'b0, ringing}, 8'd1);
    applyStimulus(RING_SECS - 1);
    checkOutput("ring_last_cycle", {7'b0, ringing}, 8'd1);
    applyStimulus(1);
    checkOutput("ring_timeout", {7'b0, ringing}, 8'd0);
    checkOutput("armed_after_timeout", {7'b0, armed}, 8'd1);

    offerTime(23, 58);
    setTime(23, 57, 58);
    applyStimulus(4);
    pulseSnooze();
    checkOutput("snooze_entered", {7'b0, snooze_active}, 8'd1);
    checkOutput("snooze_count_1", {5'b0, snooze_count}, 8'd1);
    setTime(7, 29, 58);
    applyStimulus(4);
    checkOutput("main_match_ignored", {7'b0, ringing}, 8'd0);
    setTime(0, 2, 57);
    applyStimulus(4);
    checkOutput("snooze_wrap_ring", {7'b0, ringing}, 8'd1);
    pulseSnooze();
    setTime(0, 7, 58);
    applyStimulus(3);
    pulseSnooze();
    setTime(0, 12, 58);
    applyStimulus(3);
    checkOutput("third_snooze_ring", {7'b0, ringing}, 8'd1);
    pulseSnooze();
    checkOutput("fourth_snooze_ignored", {7'b0, ringing}, 8'd1);
    dismiss = 1'b1; applyStimulus(1); dismiss = 1'b0;
    checkOutput("dismiss_clears_count", {5'b0, snooze_count}, 8'd0);

    setTime(23, 57, 59);
    applyStimulus(2);
    snooze = 1'b1; dismiss = 1'b1;
    applyStimulus(1);
    snooze = 1'b0; dismiss = 1'b0;
    checkOutput("dismiss_beats_snooze", {7'b0, snooze_active}, 8'd0);

    set_valid = 1'b1; set_hour = 5'd24; set_min = 6'd10;
    applyStimulus(1);
    set_valid = 1'b0;
    checkOutput("set_err_pulse", {7'b0, set_err}, 8'd1);
    applyStimulus(1);

    setTime(23, 57, 59);
    applyStimulus(2);
    set_valid = 1'b1; set_hour = 5'd6; set_min = 6'd15;
    applyStimulus(3);
    dismiss = 1'b1; applyStimulus(1); dismiss = 1'b0;
    applyStimulus(1);
    set_valid = 1'b0;
    checkOutput("held_set_accepted", {2'b0, alarm_min}, 8'd15);

    setTime(6, 14, 59);
    applyStimulus(2);
    arm = 1'b0; applyStimulus(1);
    checkOutput("disarm_stops_ring", {7'b0, ringing}, 8'd0);
    arm = 1'b1; applyStimulus(1);
    setTime(6, 14, 59);
    applyStimulus(2);
    reset_n = 1'b0; snooze = 1'b1; dismiss = 1'b0;
    applyStimulus(1);
    snooze = 1'b0;
    checkOutput("reset_stops_ring", {7'b0, ringing}, 8'd0);
    reset_n = 1'b1;
    applyStimulus(1);

    for (int i = 0; i < 4000; i++) begin
      arm       = ($urandom_range(0, 99) != 0);
      reset_n   = ($urandom_range(0, 499) != 0);
      snooze    = ($urandom_range(0, 7) == 0);
      dismiss   = ($urandom_range(0, 19) == 0);
      set_valid = ($urandom_range(0, 29) == 0);
      set_hour  = 5'($urandom_range(0, 25));
      set_min   = 6'($urandom_range(0, 61));
      if ($urandom_range(0, 39) == 0) begin
        k = int'($urandom_range(0, 3));
        if (mSnoozing) tod = (mSnoozeAt * 60 - k + 86400) % 86400;
        else tod = (mAlarmH * 3600 + mAlarmM * 60 - k + 86400) % 86400;
        driveTime();
      end
      applyStimulus(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
